// File: rtl/sram_1p_ctrl_pkg.sv
// Shared types and default geometry for the single-port SRAM RMW arbiter.
//   state_e        : arbiter FSM state encoding
//   SramAddrWidth  : default word-address width of the 8192x32 macro
//   SramDataWidth  : default word width of the macro
package sram_1p_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RMW_RD = 2'd1,
      RMW_WR = 2'd2
   } state_e;

   localparam int SramAddrWidth = 13;
   localparam int SramDataWidth = 32;

endpackage

// File: rtl/sram_rr_picker.sv
// Combinational round-robin picker. Scans the request vector starting at
// rr_ptr (wrapping) and grants the first requester found.
//   req     : per-port request vector
//   rr_ptr  : index of the highest-priority port this cycle
//   enable  : when low, no grant is produced
//   gnt     : one-hot grant
//   idx     : index of the granted port (0 when none)
module sram_rr_picker #(
   parameter int NumPorts = 2,
   parameter int PtrWidth = 1
) (
   input  logic [NumPorts-1:0] req,
   input  logic [PtrWidth-1:0] rr_ptr,
   input  logic                enable,
   output logic [NumPorts-1:0] gnt,
   output logic [PtrWidth-1:0] idx
);

   always_comb begin
      logic                found;
      int                  kk;
      logic [PtrWidth-1:0] k;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      kk    = 0;
      k     = '0;
      for (int i = 0; i < NumPorts; i++) begin
         kk = int'(rr_ptr) + i;
         if (kk >= NumPorts) kk = kk - NumPorts;
         k = PtrWidth'(kk);
         if (enable && !found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = k;
         end
      end
   end

endmodule

// File: rtl/sram_1p_rmw_arbiter.sv
// Shares one single-port SRAM macro between NumPorts req/gnt requesters with
// round-robin arbitration. Partial writes become an internal read-modify-write
// because the macro has no byte enables.
//   clk_i/rst_ni            : clock (also macro clock), async active-low reset
//   req_i/we_i/addr_i/...   : flattened per-port request bus
//   gnt_o                   : combinational one-hot grant
//   rvalid_o/rdata_o        : one-hot response valid, shared read data
//   sram_*_o / sram_dout_i  : macro interface (A_MEN/A_WEN/A_REN/A_ADDR/A_DIN/A_DLY/A_DOUT)
//
// state  | meaning
// IDLE   | arbitrate; single-cycle reads/writes issued directly
// RMW_RD | old word is on sram_dout_i; write the merged word, no grant
// RMW_WR | merged write done; respond to the RMW owner and arbitrate again
module sram_1p_rmw_arbiter
   import sram_1p_ctrl_pkg::*;
#(
   parameter int NumPorts  = 2,
   parameter int AddrWidth = SramAddrWidth,
   parameter int DataWidth = SramDataWidth
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [NumPorts-1:0]               req_i,
   input  logic [NumPorts-1:0]               we_i,
   input  logic [NumPorts*AddrWidth-1:0]     addr_i,
   input  logic [NumPorts*DataWidth-1:0]     wdata_i,
   input  logic [NumPorts*(DataWidth/8)-1:0] be_i,
   output logic [NumPorts-1:0]               gnt_o,
   output logic [NumPorts-1:0]               rvalid_o,
   output logic [DataWidth-1:0]              rdata_o,
   output logic                              sram_men_o,
   output logic                              sram_wen_o,
   output logic                              sram_ren_o,
   output logic [AddrWidth-1:0]              sram_addr_o,
   output logic [DataWidth-1:0]              sram_din_o,
   output logic                              sram_dly_o,
   input  logic [DataWidth-1:0]              sram_dout_i
);

   localparam int BeWidth  = DataWidth / 8;
   localparam int PtrWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;

   state_e                state_q, state_d;
   logic [PtrWidth-1:0]   rr_ptr_q;
   logic [PtrWidth-1:0]   pick_idx;
   logic                  pick_en;
   logic [PtrWidth-1:0]   cap_port_q;
   logic [AddrWidth-1:0]  cap_addr_q;
   logic [DataWidth-1:0]  cap_wdata_q;
   logic [BeWidth-1:0]    cap_be_q;
   logic                  cap_load;
   logic [NumPorts-1:0]   rv_q, rv_d;
   logic                  rd_q, rd_d;
   logic [AddrWidth-1:0]  addr_hold_q;
   logic [DataWidth-1:0]  din_hold_q;
   logic                  sel_we;
   logic [AddrWidth-1:0]  sel_addr;
   logic [DataWidth-1:0]  sel_wdata;
   logic [BeWidth-1:0]    sel_be;
   logic [DataWidth-1:0]  merged;

   // Gating with rst_ni keeps every combinational output quiet while in reset.
   assign pick_en = rst_ni && (state_q != RMW_RD);

   sram_rr_picker #(
      .NumPorts (NumPorts),
      .PtrWidth (PtrWidth)
   ) u_picker (
      .req    (req_i),
      .rr_ptr (rr_ptr_q),
      .enable (pick_en),
      .gnt    (gnt_o),
      .idx    (pick_idx)
   );

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_be    = '0;
      for (int p = 0; p < NumPorts; p++) begin
         if (gnt_o[p]) begin
            sel_we    = we_i[p];
            sel_addr  = addr_i[p*AddrWidth +: AddrWidth];
            sel_wdata = wdata_i[p*DataWidth +: DataWidth];
            sel_be    = be_i[p*BeWidth +: BeWidth];
         end
      end
   end

   always_comb begin
      merged = '0;
      for (int b = 0; b < BeWidth; b++) begin
         merged[b*8 +: 8] = cap_be_q[b] ? cap_wdata_q[b*8 +: 8] : sram_dout_i[b*8 +: 8];
      end
   end

   always_comb begin
      state_d     = state_q;
      sram_men_o  = 1'b0;
      sram_wen_o  = 1'b0;
      sram_ren_o  = 1'b0;
      sram_addr_o = addr_hold_q;
      sram_din_o  = din_hold_q;
      rv_d        = '0;
      rd_d        = 1'b0;
      cap_load    = 1'b0;
      case (state_q)
         RMW_RD: begin
            sram_men_o       = 1'b1;
            sram_wen_o       = 1'b1;
            sram_addr_o      = cap_addr_q;
            sram_din_o       = merged;
            rv_d[cap_port_q] = 1'b1;
            state_d          = RMW_WR;
         end
         default: begin
            // RMW_WR arbitrates like IDLE; the RMW response leaves rv_q this cycle.
            state_d = IDLE;
            if (|gnt_o) begin
               rv_d = gnt_o;
               if (!sel_we) begin
                  sram_men_o  = 1'b1;
                  sram_ren_o  = 1'b1;
                  sram_addr_o = sel_addr;
                  rd_d        = 1'b1;
               end else if (&sel_be) begin
                  sram_men_o  = 1'b1;
                  sram_wen_o  = 1'b1;
                  sram_addr_o = sel_addr;
                  sram_din_o  = sel_wdata;
               end else if (|sel_be) begin
                  rv_d        = '0;
                  sram_men_o  = 1'b1;
                  sram_ren_o  = 1'b1;
                  sram_addr_o = sel_addr;
                  cap_load    = 1'b1;
                  state_d     = RMW_RD;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         cap_port_q  <= '0;
         cap_addr_q  <= '0;
         cap_wdata_q <= '0;
         cap_be_q    <= '0;
         rv_q        <= '0;
         rd_q        <= 1'b0;
         addr_hold_q <= '0;
         din_hold_q  <= '0;
      end else begin
         state_q     <= state_d;
         rv_q        <= rv_d;
         rd_q        <= rd_d;
         addr_hold_q <= sram_addr_o;
         din_hold_q  <= sram_din_o;
         if (|gnt_o) begin
            rr_ptr_q <= (pick_idx == PtrWidth'(NumPorts - 1)) ? '0 : pick_idx + 1'b1;
         end
         if (cap_load) begin
            cap_port_q  <= pick_idx;
            cap_addr_q  <= sel_addr;
            cap_wdata_q <= sel_wdata;
            cap_be_q    <= sel_be;
         end
      end
   end

   assign rvalid_o   = rv_q;
   assign rdata_o    = rd_q ? sram_dout_i : '0;
   assign sram_dly_o = 1'b1;

endmodule
